// File: rtl/gen_gpi_inputs_pkg.sv
// Shared definitions for the general-purpose input block.
// Holds the named GPI bit positions, the register address map, widths,
// and the packed Avalon-MM request payload.
package gen_gpi_inputs_pkg;

    localparam int unsigned GPI_DATA_W = 32;
    localparam int unsigned GPI_ADDR_W = 2;
    localparam int unsigned GPI_CNT_W  = 8;

    // Board signal positions within gpi_async / gpi_level
    localparam int unsigned GPI_PLTRST_N_BIT_POS      = 0;
    localparam int unsigned GPI_SLP_S3_N_BIT_POS      = 1;
    localparam int unsigned GPI_BMC_BOOT_DONE_BIT_POS = 2;
    localparam int unsigned GPI_ME_DONE_BIT_POS       = 3;

    // Register word addresses
    localparam logic [GPI_ADDR_W-1:0] GPI_LEVEL_ADDR  = 2'd0;
    localparam logic [GPI_ADDR_W-1:0] GPI_RISE_ADDR   = 2'd1;
    localparam logic [GPI_ADDR_W-1:0] GPI_FALL_ADDR   = 2'd2;
    localparam logic [GPI_ADDR_W-1:0] GPI_IRQ_EN_ADDR = 2'd3;

    // One Avalon-MM slave request as seen on a single clock
    typedef struct packed {
        logic [GPI_ADDR_W-1:0] address;
        logic                  read;
        logic                  write;
        logic [GPI_DATA_W-1:0] writedata;
    } gpi_avmm_req_t;

endpackage

// File: rtl/gen_gpi_inputs_debounce_bit.sv
// gpi_debounce_bit: 2-flop synchronizer followed by a stability counter.
// Ports: clk, resetn (async active-low), gpi_async (raw input),
//        level (debounced, registered output).
module gpi_debounce_bit
    import gen_gpi_inputs_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic gpi_async,
    output logic level
);

    logic                 sync1;
    logic                 sync2;
    logic [GPI_CNT_W-1:0] cnt;

    // Synchronizer and debounce counter. For a single bit, any change of the
    // synchronized value while it differs from level must have come from a
    // cycle where it equalled level, which already cleared the counter; so
    // the counter restarts implicitly and counts the first differing cycle,
    // giving exactly DEBOUNCE_CYCLES cycles from sync2 change to level change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= gpi_async;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == GPI_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + GPI_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gen_gpi_inputs.sv
// gen_gpi_inputs: debounced general-purpose inputs with edge-sticky flags,
// interrupt enable and an Avalon-MM slave register interface.
// Ports: clk, resetn (async active-low), gpi_async (raw inputs),
//        avmm_address/read/write/writedata/readdata (register bus, read
//        latency 1), gpi_level (debounced levels), irq (registered level irq).
module gen_gpi_inputs
    import gen_gpi_inputs_pkg::*;
#(
    parameter int unsigned N_GPI           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_GPI-1:0] gpi_async,
    input  logic [1:0]       avmm_address,
    input  logic             avmm_read,
    input  logic             avmm_write,
    input  logic [31:0]      avmm_writedata,
    output logic [31:0]      avmm_readdata,
    output logic [N_GPI-1:0] gpi_level,
    output logic             irq
);

    gpi_avmm_req_t    req_c;
    logic [N_GPI-1:0] level_d;
    logic [N_GPI-1:0] rise_sticky;
    logic [N_GPI-1:0] fall_sticky;
    logic [N_GPI-1:0] irq_enable;
    logic [N_GPI-1:0] wr_bits_c;
    logic [N_GPI-1:0] rise_set_c;
    logic [N_GPI-1:0] fall_set_c;
    logic [N_GPI-1:0] rise_clr_c;
    logic [N_GPI-1:0] fall_clr_c;
    logic [31:0]      rd_mux_c;

    assign req_c = '{address:   avmm_address,
                     read:      avmm_read,
                     write:     avmm_write,
                     writedata: avmm_writedata};

    // Per-input synchronizer and debounce
    for (genvar i = 0; i < int'(N_GPI); i++) begin : g_bit
        gpi_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .resetn   (resetn),
            .gpi_async(gpi_async[i]),
            .level    (gpi_level[i])
        );
    end

    // Edge detection against the previous debounced level and W1C strobes
    always_comb begin
        wr_bits_c  = req_c.writedata[N_GPI-1:0];
        rise_set_c = gpi_level & ~level_d;
        fall_set_c = ~gpi_level & level_d;
        rise_clr_c = '0;
        fall_clr_c = '0;
        if (req_c.write && req_c.address == GPI_RISE_ADDR) rise_clr_c = wr_bits_c;
        if (req_c.write && req_c.address == GPI_FALL_ADDR) fall_clr_c = wr_bits_c;
    end

    // Read mux; unimplemented upper bits are zero-extended
    always_comb begin
        rd_mux_c = '0;
        case (req_c.address)
            GPI_LEVEL_ADDR:  rd_mux_c = 32'(gpi_level);
            GPI_RISE_ADDR:   rd_mux_c = 32'(rise_sticky);
            GPI_FALL_ADDR:   rd_mux_c = 32'(fall_sticky);
            GPI_IRQ_EN_ADDR: rd_mux_c = 32'(irq_enable);
            default:         rd_mux_c = '0;
        endcase
    end

    // Registers: sticky set wins over a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_d       <= '0;
            rise_sticky   <= '0;
            fall_sticky   <= '0;
            irq_enable    <= '0;
            avmm_readdata <= '0;
            irq           <= 1'b0;
        end else begin
            level_d     <= gpi_level;
            rise_sticky <= (rise_sticky & ~rise_clr_c) | rise_set_c;
            fall_sticky <= (fall_sticky & ~fall_clr_c) | fall_set_c;
            if (req_c.write && req_c.address == GPI_IRQ_EN_ADDR) irq_enable <= wr_bits_c;
            if (req_c.read) avmm_readdata <= rd_mux_c;
            irq <= |((rise_sticky | fall_sticky) & irq_enable);
        end
    end

endmodule

// File: tb/tb_gen_gpi_inputs.sv
// Self-checking bench for gen_gpi_inputs (N_GPI=32, DEBOUNCE_CYCLES=4).
// Register reads push their expected value into a scoreboard queue when
// issued; a monitor pops and compares when the registered read data appears.
module tb_gen_gpi_inputs;

    localparam int unsigned N  = 32;
    localparam int unsigned DB = 4;

    logic          clk;
    logic          resetn;
    logic [N-1:0]  gpi_async;
    logic [1:0]    avmm_address;
    logic          avmm_read;
    logic          avmm_write;
    logic [31:0]   avmm_writedata;
    logic [31:0]   avmm_readdata;
    logic [N-1:0]  gpi_level;
    logic          irq;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [31:0]   exp_q[$];
    string         tag_q[$];
    logic          rd_pend;

    gen_gpi_inputs #(
        .N_GPI          (N),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .gpi_async     (gpi_async),
        .avmm_address  (avmm_address),
        .avmm_read     (avmm_read),
        .avmm_write    (avmm_write),
        .avmm_writedata(avmm_writedata),
        .avmm_readdata (avmm_readdata),
        .gpi_level     (gpi_level),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus cycle driven from a negedge; reads queue their expected data
    task automatic bus(input logic rd, input logic wr, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        avmm_address   = addr;
        avmm_read      = rd;
        avmm_write     = wr;
        avmm_writedata = wdata;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        avmm_read  = 1'b0;
        avmm_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        bus(1'b1, 1'b0, addr, 32'h0, exp, tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus(1'b0, 1'b1, addr, data, 32'h0, "");
    endtask

    // Scoreboard monitor: read data is valid one cycle after the read strobe
    always @(posedge clk or negedge resetn) begin
        if (!resetn) rd_pend <= 1'b0;
        else         rd_pend <= avmm_read;
    end

    always @(negedge clk) begin : mon
        logic [31:0] e;
        string       t;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_eq(t, avmm_readdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b0;
        gpi_async      = '0;
        avmm_address   = 2'd0;
        avmm_read      = 1'b0;
        avmm_write     = 1'b0;
        avmm_writedata = 32'h0;
        wait_neg(3);
        check_eq("rst_level", gpi_level, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_rdata", avmm_readdata, 32'h0);
        resetn = 1'b1;
        wait_neg(2);
        rd(2'd0, 32'h0, "rst_reg0");
        rd(2'd1, 32'h0, "rst_reg1");
        rd(2'd2, 32'h0, "rst_reg2");
        rd(2'd3, 32'h0, "rst_reg3");

        // Clean step on bit 3: level changes exactly 2+DB cycles later
        gpi_async[3] = 1'b1;
        wait_neg(5);
        check_eq("step_pre", gpi_level, 32'h0);
        wait_neg(1);
        check_eq("step_post", gpi_level, 32'h8);
        wait_neg(2);
        rd(2'd1, 32'h8, "step_rise");
        rd(2'd2, 32'h0, "step_fall");
        rd(2'd0, 32'h8, "step_level");

        // Glitch of DB-1 cycles on bit 0 is rejected
        gpi_async[0] = 1'b1;
        wait_neg(DB - 1);
        gpi_async[0] = 1'b0;
        wait_neg(10);
        check_eq("glitch_level", gpi_level, 32'h8);
        rd(2'd1, 32'h8, "glitch_rise");

        // Pulse of exactly DB cycles passes, then falls back
        gpi_async[0] = 1'b1;
        wait_neg(DB);
        gpi_async[0] = 1'b0;
        wait_neg(12);
        check_eq("pulse_level", gpi_level, 32'h8);
        rd(2'd1, 32'h9, "pulse_rise");
        rd(2'd2, 32'h1, "pulse_fall");

        // W1C: written ones clear, written zeros hold
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h8, "w1c_rise");
        wr(2'd2, 32'hFFFF_FFFE);
        rd(2'd2, 32'h1, "w1c_hold");
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h0, "w1c_fall");

        // Rise set on bit 5 in the same cycle as its clear: set wins
        gpi_async[5] = 1'b1;
        wait_neg(6);
        wr(2'd1, 32'h20);
        rd(2'd1, 32'h28, "collide_rise");
        wr(2'd1, 32'h20);
        rd(2'd1, 32'h8, "clear5_rise");

        // Level register ignores writes
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h28, "level_ro");

        // Simultaneous read and write returns pre-write contents
        bus(1'b1, 1'b1, 2'd3, 32'h8, 32'h0, "rw_pre");
        rd(2'd3, 32'h8, "rw_post");

        // IRQ from pending rise on bit 3, then clear it
        check_eq("irq_rise", 32'(irq), 32'h1);
        wr(2'd1, 32'h8);
        check_eq("irq_rise_hold", 32'(irq), 32'h1);
        wait_neg(1);
        check_eq("irq_rise_clr", 32'(irq), 32'h0);

        // IRQ from fall on bit 3, clear via fall register
        gpi_async[3] = 1'b0;
        wait_neg(8);
        check_eq("irq_fall", 32'(irq), 32'h1);
        rd(2'd2, 32'h8, "fall3");
        wr(2'd2, 32'h8);
        check_eq("irq_fall_hold", 32'(irq), 32'h1);
        wait_neg(1);
        check_eq("irq_fall_clr", 32'(irq), 32'h0);

        // Reset mid-debounce with all inputs high
        gpi_async = '1;
        wait_neg(3);
        resetn = 1'b0;
        #1;
        check_eq("mrst_level", gpi_level, 32'h0);
        check_eq("mrst_irq", 32'(irq), 32'h0);
        check_eq("mrst_rdata", avmm_readdata, 32'h0);
        wait_neg(2);
        resetn = 1'b1;
        wait_neg(5);
        check_eq("mrst_pre", gpi_level, 32'h0);
        wait_neg(1);
        check_eq("mrst_post", gpi_level, 32'hFFFF_FFFF);
        wait_neg(2);
        rd(2'd1, 32'hFFFF_FFFF, "mrst_rise");
        rd(2'd2, 32'h0, "mrst_fall");
        rd(2'd3, 32'h0, "mrst_irq_en");
        check_eq("mrst_irq_off", 32'(irq), 32'h0);

        wait_neg(2);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_gpi_inputs.md
GEN_GPI_INPUTS -- requirements
Module: gen_gpi_inputs

Interface
REQ-001 SHALL have parameter N_GPI, default 32: number of general-purpose inputs, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable clk cycles required before the filtered level changes, 1..255.
REQ-003 SHALL have port clk, input, 1: single system clock for all logic.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port gpi_async, input, N_GPI: raw board-level inputs, asynchronous to clk.
REQ-006 SHALL have port avmm_address, input, 2: word address.
REQ-007 SHALL have port avmm_read, input, 1: read strobe.
REQ-008 SHALL have port avmm_write, input, 1: write strobe.
REQ-009 SHALL have port avmm_writedata, input, 32: write data.
REQ-010 SHALL have port avmm_readdata, output, 32: read data.
REQ-011 SHALL have port gpi_level, output, N_GPI: debounced levels, for direct fabric use.
REQ-012 SHALL have port irq, output, 1: level interrupt to Nios.

Function
REQ-013 Each gpi_async bit SHALL pass a 2-flop synchronizer; the synchronizer adds 2 cycles of latency.
REQ-014 Each bit SHALL have a stability counter.
- The counter clears whenever the synchronized value equals gpi_level, or whenever the synchronized value changed since the previous cycle.
- Otherwise the counter increments.
- When the count reaches DEBOUNCE_CYCLES-1, gpi_level takes the synchronized value and the counter clears.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) SHALL NOT change gpi_level.
REQ-016 Total latency from a clean input step to gpi_level SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-017 A 0->1 change of gpi_level[i] SHALL set rise_sticky[i]; a 1->0 change SHALL set fall_sticky[i].
REQ-018 Register map:
- addr 0: gpi_level, read-only.
- addr 1: rise_sticky, write-1-to-clear.
- addr 2: fall_sticky, write-1-to-clear.
- addr 3: irq_enable, read/write.
REQ-019 On a W1C write, a bit written 1 SHALL clear; a bit written 0 SHALL hold.
REQ-020 If a sticky set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-021 Writes to addr 0 SHALL be ignored.
REQ-022 Reads SHALL have fixed latency 1: avmm_readdata is registered on the cycle after avmm_read and holds until the next read.
REQ-023 Bits at and above N_GPI SHALL read 0 and ignore writes.
REQ-024 irq SHALL be registered and equal to |((rise_sticky | fall_sticky) & irq_enable), one cycle after the contributing state.
REQ-025 Simultaneous avmm_read and avmm_write SHALL both execute; the read returns pre-write contents.

Reset
REQ-026 On resetn low, all registers SHALL clear asynchronously: synchronizers, counters, gpi_level, stickies, irq_enable, avmm_readdata and irq all = 0.
REQ-027 Reset release SHALL NOT create sticky flags for inputs already high; the first rise is recorded only after gpi_level settles from 0 to 1.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-029 A shared package gen_gpi_inputs_pkg SHALL hold:
- the GPI_<signal>_BIT_POS localparams, mirroring the GPO package scheme (e.g. PLTRST_N, SLP_S3_N, BMC_BOOT_DONE, ME_DONE);
- the register address localparams GPI_LEVEL_ADDR=0, GPI_RISE_ADDR=1, GPI_FALL_ADDR=2, GPI_IRQ_EN_ADDR=3.
REQ-030 Per-bit synchronizer plus debounce SHALL be the sub-module gpi_debounce_bit, instantiated N_GPI times in a generate loop.

Verification
REQ-031 Clean step: gpi_async[3] 0->1 at cycle 10, DEBOUNCE_CYCLES=4 -> gpi_level[3]=1 at cycle 16; rise_sticky reads 0x8.
REQ-032 Glitch: gpi_async[0] high for 3 cycles -> gpi_level[0] stays 0; rise_sticky stays 0.
REQ-033 W1C: rise_sticky=0x9, write 0x1 to addr 1 -> reads back 0x8.
REQ-034 Set/clear collision: rise set and clear on bit 5 in the same cycle -> bit 5 reads 1.
REQ-035 IRQ: irq_enable=0x8 with fall on bit 3 -> irq=1; clear bit 3 via addr 2 -> irq=0 one cycle later.
REQ-036 Reset: assert resetn low mid-debounce with inputs at all ones, then release -> all registers 0; gpi_level reaches 0xFFFFFFFF after 6 cycles; rise_sticky=0xFFFFFFFF.
